// File: rtl/sdram_frame_scheduler_pkg.sv
// sdram_sched_pkg: shared FSM encoding and widths for the SDRAM frame scheduler.
package sdram_sched_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;
    localparam int IDX_W = 2;
    localparam int CNT_W = 16;
endpackage

// File: rtl/sdram_frame_scheduler_load_pulse_gen.sv
// load_pulse_gen: a start in cycle t holds o_load high for cycles t+1 .. t+LOAD_W.
module load_pulse_gen #(
    parameter int LOAD_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_load,
    output logic o_busy
);
    localparam int CW = $clog2(LOAD_W + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_start)
            r_cnt <= CW'(LOAD_W);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end
    assign o_load = r_cnt != '0;
    assign o_busy = o_load;
endmodule

// File: rtl/sdram_frame_scheduler.sv
// sdram_frame_scheduler: tear-free double/triple frame-buffer rotation for the two-port SDRAM controller.
// Buffers swap only on frame events; each swap reloads the port with registered min/max addresses.
module sdram_frame_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int                ADDR_W     = 21,
    parameter logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(480000),
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                NUM_BUF    = 3,
    parameter int                LOAD_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sdram_init_done,
    input  logic              i_wr_frame_done,
    input  logic              i_rd_frame_start,
    output logic              o_wr_load,
    output logic [ADDR_W-1:0] o_wr_addr_min,
    output logic [ADDR_W-1:0] o_wr_addr_max,
    output logic              o_wr_enable,
    output logic              o_rd_load,
    output logic [ADDR_W-1:0] o_rd_addr_min,
    output logic [ADDR_W-1:0] o_rd_addr_max,
    output logic              o_rd_valid,
    output logic [IDX_W-1:0]  o_wr_idx,
    output logic [IDX_W-1:0]  o_rd_idx,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [CNT_W-1:0]  o_repeat_cnt
);
    function automatic logic [ADDR_W-1:0] buf_min(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + ADDR_W'(idx) * FRAME_SIZE;
    endfunction

    state_t r_state, w_state_n;
    logic w_init, w_run;
    logic [IDX_W-1:0] r_wr_idx, r_rd_idx, r_ready_idx, w_wr_idx_n, w_rd_idx_n, w_ready_idx_n;
    logic r_ready, r_wr_pend, r_rd_pend, r_wr_act, r_rd_act;
    logic w_ready_n, w_wr_act_n, w_wr_svc, w_rd_svc, w_wr_start, w_rd_start, w_drop_inc, w_rep_inc;
    logic w_wr_load, w_wr_busy, w_rd_load, w_rd_busy;
    logic [ADDR_W-1:0] r_wr_min, r_wr_max, r_rd_min, r_rd_max;
    logic [CNT_W-1:0] r_drop, r_rep;

    load_pulse_gen #(.LOAD_W(LOAD_W)) u_wr_pulse (
        .clk(clk), .rst_n(rst_n), .i_start(w_wr_start), .o_load(w_wr_load), .o_busy(w_wr_busy)
    );
    load_pulse_gen #(.LOAD_W(LOAD_W)) u_rd_pulse (
        .clk(clk), .rst_n(rst_n), .i_start(w_rd_start), .o_load(w_rd_load), .o_busy(w_rd_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state == ST_IDLE ? (i_sdram_init_done ? ST_INIT : ST_IDLE) : ST_RUN;
    end

    always_comb begin
        w_init = r_state == ST_INIT;
        w_run  = r_state == ST_RUN;
    end

    assign w_wr_svc = w_run && r_wr_pend && !w_wr_busy;
    assign w_rd_svc = w_run && r_rd_pend && !w_rd_busy;

    // Write service resolves first so a simultaneous read service displays the just-finished frame.
    always_comb begin
        w_wr_idx_n    = w_init ? '0 : r_wr_idx;
        w_rd_idx_n    = w_init ? IDX_W'(NUM_BUF - 1) : r_rd_idx;
        w_wr_act_n    = r_wr_act | w_init;
        w_wr_start    = w_init;
        w_rd_start    = w_init;
        w_ready_n     = r_ready;
        w_ready_idx_n = r_ready_idx;
        w_drop_inc    = 1'b0;
        w_rep_inc     = 1'b0;
        if (w_wr_svc) begin
            w_drop_inc    = r_ready;
            w_ready_n     = 1'b1;
            w_ready_idx_n = r_wr_idx;
            if (NUM_BUF == 3) begin
                w_wr_idx_n = IDX_W'(3) - r_rd_idx - r_wr_idx;
                w_wr_start = 1'b1;
            end else
                w_wr_act_n = 1'b0;
        end
        if (w_rd_svc) begin
            w_rep_inc = !w_ready_n;
            if (w_ready_n) begin
                w_rd_idx_n = w_ready_idx_n;
                w_ready_n  = 1'b0;
                w_rd_start = 1'b1;
                if (NUM_BUF == 2) begin
                    w_wr_idx_n = r_rd_idx;
                    w_wr_act_n = 1'b1;
                    w_wr_start = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_ready     <= 1'b0;
            r_ready_idx <= '0;
            r_wr_pend   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_wr_act    <= 1'b0;
            r_rd_act    <= 1'b0;
            r_wr_min    <= '0;
            r_wr_max    <= '0;
            r_rd_min    <= '0;
            r_rd_max    <= '0;
            r_drop      <= '0;
            r_rep       <= '0;
        end else begin
            r_wr_idx    <= w_wr_idx_n;
            r_rd_idx    <= w_rd_idx_n;
            r_ready     <= w_ready_n;
            r_ready_idx <= w_ready_idx_n;
            r_wr_pend   <= (w_run && i_wr_frame_done) || (r_wr_pend && !w_wr_svc);
            r_rd_pend   <= (w_run && i_rd_frame_start) || (r_rd_pend && !w_rd_svc);
            r_wr_act    <= w_wr_act_n;
            r_rd_act    <= r_rd_act | w_init;
            if (w_wr_start) begin
                r_wr_min <= buf_min(w_wr_idx_n);
                r_wr_max <= buf_min(w_wr_idx_n) + FRAME_SIZE;
            end
            if (w_rd_start) begin
                r_rd_min <= buf_min(w_rd_idx_n);
                r_rd_max <= buf_min(w_rd_idx_n) + FRAME_SIZE;
            end
            if (w_drop_inc && !(&r_drop))
                r_drop <= r_drop + 1'b1;
            if (w_rep_inc && !(&r_rep))
                r_rep <= r_rep + 1'b1;
        end
    end

    assign o_wr_load     = w_wr_load;
    assign o_rd_load     = w_rd_load;
    assign o_wr_enable   = r_wr_act && !w_wr_load;
    assign o_rd_valid    = r_rd_act && !w_rd_load;
    assign o_wr_addr_min = r_wr_min;
    assign o_wr_addr_max = r_wr_max;
    assign o_rd_addr_min = r_rd_min;
    assign o_rd_addr_max = r_rd_max;
    assign o_wr_idx      = r_wr_idx;
    assign o_rd_idx      = r_rd_idx;
    assign o_drop_cnt    = r_drop;
    assign o_repeat_cnt  = r_rep;
endmodule

// File: tb/tb_sdram_frame_scheduler.sv
// tb_sdram_frame_scheduler: triple- and double-buffer instances driven by shared random frame events.
// A buffer-level model queues expected load pulses; a negedge monitor pops them as pulses appear.
module tb_sdram_frame_scheduler;
    localparam int FS = 480000;
    localparam int LW = 4;

    logic clk = 1'b0, rst_n = 1'b0, init = 1'b0, wfd = 1'b0, rfs = 1'b0;
    logic wl[2], we[2], rl[2], rv[2];
    logic [20:0] wmin[2], wmax[2], rmin[2], rmax[2];
    logic [1:0] wi[2], ri[2];
    logic [15:0] dc[2], rc[2];

    int checks = 0, errors = 0;
    bit mon_en = 1'b0, inv_en = 1'b0;
    int q[4][$];
    bit prev[4];
    int wid[4];
    int m_wr[2], m_rd[2], m_rdi[2], m_drop[2], m_rep[2];
    bit m_rdy[2], m_wen[2];

    always #5 clk = ~clk;

    sdram_frame_scheduler #(.NUM_BUF(3), .LOAD_W(LW)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_sdram_init_done(init), .i_wr_frame_done(wfd), .i_rd_frame_start(rfs),
        .o_wr_load(wl[0]), .o_wr_addr_min(wmin[0]), .o_wr_addr_max(wmax[0]), .o_wr_enable(we[0]),
        .o_rd_load(rl[0]), .o_rd_addr_min(rmin[0]), .o_rd_addr_max(rmax[0]), .o_rd_valid(rv[0]),
        .o_wr_idx(wi[0]), .o_rd_idx(ri[0]), .o_drop_cnt(dc[0]), .o_repeat_cnt(rc[0])
    );
    sdram_frame_scheduler #(.NUM_BUF(2), .LOAD_W(LW)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_sdram_init_done(init), .i_wr_frame_done(wfd), .i_rd_frame_start(rfs),
        .o_wr_load(wl[1]), .o_wr_addr_min(wmin[1]), .o_wr_addr_max(wmax[1]), .o_wr_enable(we[1]),
        .o_rd_load(rl[1]), .o_rd_addr_min(rmin[1]), .o_rd_addr_max(rmax[1]), .o_rd_valid(rv[1]),
        .o_wr_idx(wi[1]), .o_rd_idx(ri[1]), .o_drop_cnt(dc[1]), .o_repeat_cnt(rc[1])
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbuf(input int d);
        return d == 0 ? 3 : 2;
    endfunction

    // Frame-level reference: track which buffer each role owns and push expected loads.
    task automatic model_wr(input int d);
        int nw;
        nw = m_wr[d];
        if (m_rdy[d]) m_drop[d]++;
        m_rdy[d] = 1'b1;
        m_rdi[d] = m_wr[d];
        if (nbuf(d) == 3) begin
            for (int b = 0; b < 3; b++)
                if (b != m_rd[d] && b != m_rdi[d]) nw = b;
            m_wr[d] = nw;
            q[2*d].push_back(nw);
        end else
            m_wen[d] = 1'b0;
    endtask

    task automatic model_rd(input int d);
        int old;
        if (m_rdy[d]) begin
            old = m_rd[d];
            m_rd[d] = m_rdi[d];
            m_rdy[d] = 1'b0;
            q[2*d+1].push_back(m_rd[d]);
            if (nbuf(d) == 2) begin
                m_wr[d] = old;
                m_wen[d] = 1'b1;
                q[2*d].push_back(old);
            end
        end else
            m_rep[d]++;
    endtask

    task automatic mon(input int k, input logic ld, input logic [1:0] idx, input logic [20:0] mn,
                       input logic [20:0] mx, input logic en);
        int e;
        if (ld && !prev[k]) begin
            chk($sformatf("load_expected[%0d]", k), q[k].size() > 0, 1);
            if (q[k].size() > 0) begin
                e = q[k].pop_front();
                chk($sformatf("load_idx[%0d]", k), idx, e);
                chk($sformatf("addr_min[%0d]", k), mn, e * FS);
                chk($sformatf("addr_max[%0d]", k), mx, (e + 1) * FS);
            end
            wid[k] = 0;
        end
        if (ld) begin
            wid[k]++;
            chk($sformatf("en_low_in_pulse[%0d]", k), en, 0);
        end
        if (!ld && prev[k]) chk($sformatf("pulse_width[%0d]", k), wid[k], LW);
        prev[k] = ld;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                mon(2*d, wl[d], wi[d], wmin[d], wmax[d], we[d]);
                mon(2*d+1, rl[d], ri[d], rmin[d], rmax[d], rv[d]);
            end
        end
        if (inv_en)
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("idx_distinct[%0d]", d), wi[d] != ri[d], 1);
                chk($sformatf("idx_range[%0d]", d), wi[d] < nbuf(d) && ri[d] < nbuf(d), 1);
            end
    end

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_wr_load"}, wl[d], 0);
            chk({tag, "_rd_load"}, rl[d], 0);
            chk({tag, "_wr_en"}, we[d], 0);
            chk({tag, "_rd_valid"}, rv[d], 0);
            chk({tag, "_addrs"}, wmin[d] | wmax[d] | rmin[d] | rmax[d], 0);
            chk({tag, "_idx"}, {wi[d], ri[d]}, 0);
            chk({tag, "_cnts"}, dc[d] | rc[d], 0);
        end
    endtask

    task automatic ev(input int code, input int gap);
        @(negedge clk);
        wfd = code[0];
        rfs = code[1];
        @(negedge clk);
        wfd = 1'b0;
        rfs = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (code[0]) model_wr(d);
            if (code[1]) model_rd(d);
        end
        repeat (gap) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wr_idx[%0d]", d), wi[d], m_wr[d]);
            chk($sformatf("rd_idx[%0d]", d), ri[d], m_rd[d]);
            chk($sformatf("drop_cnt[%0d]", d), dc[d], m_drop[d]);
            chk($sformatf("repeat_cnt[%0d]", d), rc[d], m_rep[d]);
            chk($sformatf("wr_enable[%0d]", d), we[d], m_wen[d]);
            chk($sformatf("rd_valid[%0d]", d), rv[d], 1);
            chk($sformatf("loads_drained[%0d]", d), q[2*d].size() + q[2*d+1].size(), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_wr[d] = 0;
            m_rd[d] = nbuf(d) - 1;
            m_wen[d] = 1'b1;
            q[2*d].push_back(0);
            q[2*d+1].push_back(nbuf(d) - 1);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("init_no_load_yet[%0d]", d), {wl[d], rl[d]}, 0);
        repeat (LW) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) chk($sformatf("init_loads[%0d]", d), {wl[d], rl[d], we[d], rv[d]}, 4'b1100);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("init_done_en[%0d]", d), {wl[d], rl[d], we[d], rv[d]}, 4'b0011);
        inv_en = 1'b1;
        init = 1'b0;
        ev(1, 100);
        ev(2, 20);
        ev(1, 15);
        ev(1, 15);
        ev(2, 15);
        ev(2, 15);
        ev(3, 15);
        ev(1, 12);
        ev(3, 12);
        for (int i = 0; i < 80; i++) ev($urandom_range(1, 3), $urandom_range(10, 25));
        @(negedge clk);
        wfd = 1'b1;
        @(negedge clk);
        wfd = 1'b0;
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        inv_en = 1'b0;
        chk("midpulse_wr_load", wl[0], 1);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_frame_scheduler.md
Name: sdram_frame_scheduler

Overview:
- Frame-buffer scheduler for the two-port SDRAM controller.
- Divides SDRAM into NUM_BUF frame buffers and tracks which buffer the writer fills and which the display reader scans.
- Drives the write-port and read-port load strobes and min/max addresses so frames swap only at frame boundaries, giving tear-free double or triple buffering.
- Runs in the SDRAM controller clock domain; frame events arrive already synchronized.

Parameters:
- ADDR_W, 21, SDRAM word-address width.
- FRAME_SIZE, 21'd480000, words per frame (H_DISP*V_DISP).
- BASE_ADDR, 21'd0, start address of buffer 0.
- NUM_BUF, 3, buffer count; only 2 or 3 are legal.
- LOAD_W, 4, load-strobe width in clocks (LOAD_W >= 1).

Ports:
- clk  in  1  SDRAM controller clock.
- rst_n  in  1  asynchronous active-low reset.
- sdram_init_done  in  1  SDRAM initialization complete (level).
- wr_frame_done  in  1  one-cycle pulse: writer finished a frame.
- rd_frame_start  in  1  one-cycle pulse: display vertical blank start.
- wr_load  out  1  write-port register load / FIFO clear.
- wr_addr_min  out  ADDR_W  write buffer start address.
- wr_addr_max  out  ADDR_W  write buffer end address (exclusive).
- wr_enable  out  1  writer may push pixels.
- rd_load  out  1  read-port register load / FIFO clear.
- rd_addr_min  out  ADDR_W  read buffer start address.
- rd_addr_max  out  ADDR_W  read buffer end address (exclusive).
- rd_valid  out  1  read port holds a valid buffer.
- wr_idx  out  2  buffer being written.
- rd_idx  out  2  buffer being displayed.
- drop_cnt  out  16  completed frames overwritten before display, saturating.
- repeat_cnt  out  16  vblanks with no new frame, saturating.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE; the ready flag and both pending flags are cleared.
- Address rule:
  - min = BASE_ADDR + idx*FRAME_SIZE; max = min + FRAME_SIZE.
  - Addresses are registered and change only in the cycle the matching load pulse starts.
  - Addresses hold stable throughout the load pulse and after it.
- Load pulse:
  - A start in cycle t drives load high for cycles t+1 .. t+LOAD_W.
  - The corresponding enable/valid output is low throughout the pulse.
- FSM, IDLE:
  - Wait for sdram_init_done = 1, then go to INIT.
- FSM, INIT:
  - Set wr_idx = 0 and rd_idx = NUM_BUF-1.
  - Start both load pulses in the same cycle, then go to RUN.
  - When both pulses end: wr_enable = 1, rd_valid = 1.
- Pending flags:
  - wr_frame_done sets wr_pend; rd_frame_start sets rd_pend.
  - Each flag is set in any state except IDLE and INIT.
  - Each flag is serviced in RUN only when that port's load counter is 0.
  - A flag cleared by service in the same cycle as a new pulse stays set.
- Write service, NUM_BUF = 3:
  - ready_idx = wr_idx. If a ready frame already existed, increment drop_cnt.
  - ready = 1. wr_idx = the buffer that is neither rd_idx nor the new ready_idx.
  - Start a wr_load pulse.
- Write service, NUM_BUF = 2:
  - ready_idx = wr_idx, ready = 1, wr_enable = 0.
  - No wr_load; the writer stalls until the next read service.
- Read service:
  - If ready = 1: rd_idx = ready_idx, ready = 0, start an rd_load pulse.
  - With NUM_BUF = 2, a read service with ready = 1 also sets wr_idx to the old rd_idx and starts a wr_load pulse.
  - If ready = 0: increment repeat_cnt; no load, and the reader rescans the same buffer.
- Simultaneous write and read service in one cycle:
  - Write service is applied first; read service then uses the updated ready.
  - Result: the frame just completed is displayed and no drop is counted for it.
- sdram_init_done deasserting in RUN is ignored.
- rst_n low at any time, including mid-pulse, returns immediately to the reset values.
- Invariant: wr_idx != rd_idx, and both are < NUM_BUF at all times in RUN.

Decomposition:
- Package sdram_sched_pkg:
  - FSM state encoding (IDLE, INIT, RUN).
  - Index width constant (2).
  - Counter width constant (16).
- Sub-module load_pulse_gen:
  - start input; load and busy outputs; counter of LOAD_W.
  - Instantiated once per port.

Test Plan:
- Init:
  - Stimulus: reset, then sdram_init_done high at cycle 10.
  - Required: wr_load and rd_load high for cycles 12-15 (LOAD_W = 4).
  - Required: wr_addr = 0/480000, rd_addr = 960000/1440000.
  - Required: wr_enable and rd_valid = 1 from cycle 16.
- Triple-buffer rotation:
  - Stimulus: wr_frame_done, then rd_frame_start 100 cycles later.
  - Required: wr_idx = 1; then rd_idx = 0 with rd_load pulse and rd_addr_min = 0.
- Drop:
  - Stimulus: two wr_frame_done pulses with no rd_frame_start between them.
  - Required: drop_cnt = 1; wr_idx never equals rd_idx.
- Repeat:
  - Stimulus: rd_frame_start with ready = 0.
  - Required: repeat_cnt increments, no rd_load, rd_idx unchanged.
- Simultaneous events:
  - Stimulus: wr_frame_done and rd_frame_start in the same cycle.
  - Required: rd_idx = the old wr_idx, drop_cnt unchanged.
- NUM_BUF = 2:
  - Stimulus: wr_frame_done.
  - Required: wr_enable = 0 until rd_frame_start; then indices swap and both load pulses fire.
